decoder_fault_detector: RTL and testbench
=========================================

Name: decoder_fault_detector

Overview:
- Sequential built-in self-test controller for an N-to-2^N decoder with enable.
- Companion to the team's priority-encoder fault detector: it exercises the decode direction of the same code space.
- Sweeps every {EN, A} combination into an external decoder-under-test and compares the returned outputs against an internal golden decoder.
- Reports a sticky fault flag, a saturating mismatch count and the first failing vector. Sits beside the decoder instance in the fault-detection test harness.

Parameters:
- N, 2, decoder select width; the decoder has 2^N outputs.
- CNT_W, N+2, fault counter width; must hold 2^(N+1) without overflow at default.

Ports:
- clk  input  1  single clock domain, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  terminate a running sweep.
- tst_a  output  N  select value driven to the decoder-under-test.
- tst_en  output  1  enable driven to the decoder-under-test.
- y_dut  input  2^N  decoder-under-test output, combinational from tst_a/tst_en.
- busy  output  1  sweep in progress.
- done  output  1  sweep completed; held high until the next start or reset.
- fault_detected  output  1  sticky; at least one mismatch in the current or last sweep.
- fault_count  output  CNT_W  number of mismatching vectors, saturates at all-ones.
- fail_valid  output  1  the first_fail_* fields hold a captured failure.
- first_fail_vec  output  N+1  {EN, A} of the first mismatch.
- first_fail_y  output  2^N  y_dut value captured at the first mismatch.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, vector index 0. All outputs 0, including tst_a, tst_en, counters and capture registers. Reset asserted mid-sweep aborts immediately and clears all results.
- Vector index vec, width N+1: EN = vec[N], A = vec[N-1:0]. Order runs 0 to 2^(N+1)-1, so all EN=0 vectors come first.
- Golden output: all zeros when EN=0; one-hot with bit A set when EN=1.
- State IDLE: busy=0. When start=1, clear fault_detected, fault_count, fail_valid, first_fail_vec, first_fail_y and done; set vec=0; go to APPLY.
- State APPLY: tst_a/tst_en are driven from vec (registered outputs, updated on entry). busy=1. Next state is CHECK, giving the decoder-under-test one full cycle to settle.
- State CHECK: compare y_dut against golden(vec) at the clock edge. On mismatch:
  - increment fault_count, unless it is all-ones;
  - set fault_detected;
  - if fail_valid=0, capture vec and y_dut into first_fail_vec/first_fail_y and set fail_valid.
  Then, if vec is the last vector, go to DONE; otherwise vec+1 and go to APPLY.
- State DONE: busy=0, done=1; tst_a/tst_en hold the last vector. start=1 clears results and restarts exactly as from IDLE.
- Latency: two cycles per vector. done rises 2*2^(N+1) clock edges after the edge that samples start (16 for N=2). Results are final in the same cycle done rises.
- start while busy: ignored.
- abort in APPLY or CHECK: go to IDLE next edge with done=0. Partial results are retained; a CHECK performed in that same cycle is still recorded.
- abort in IDLE or DONE: no effect.
- abort and start together: abort wins while busy; start wins in IDLE or DONE.
- y_dut is assumed synchronous to clk; no synchronizer.

Decomposition:
- Shared package (fault_det_pkg), holding:
  - state enumeration {IDLE, APPLY, CHECK, DONE};
  - golden one-hot decode function parameterised by N, also reusable by the encoder-side golden models.
- One natural sub-module, decoder_gold: combinational golden N-to-2^N decoder with enable. Instantiated once; the controller FSM, counter and capture logic stay in the top.

Test Plan (N=2):
1. Fault-free decoder model on tst_a/tst_en, pulse start -> done=1 after 16 edges, fault_detected=0, fault_count=0, fail_valid=0; tst_a/tst_en visit vectors 0..7 in order.
2. Output y[2] stuck-at-0 -> only vec 6 fails: fault_count=1, first_fail_vec=3'b110, first_fail_y=4'b0000, fault_detected=1.
3. Output y[0] stuck-at-1 -> vectors 0,1,2,3,5,6,7 fail: fault_count=7, first_fail_vec=3'b000, first_fail_y=4'b0001.
4. start pulsed again during a sweep -> ignored, sweep length stays 16 edges. start in DONE -> results cleared on the next edge and a new sweep runs.
5. abort asserted on the APPLY of vec 3 with y[0] stuck-at-1 -> IDLE next edge, done=0, fault_count=3, fail_valid=1.
6. rst_n pulsed low asynchronously mid-CHECK -> all outputs 0 immediately. After release the block stays IDLE until start.

Source files
------------

// File: rtl/fault_det_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fault_det_pkg
// Brief   : Shared types and golden-model helpers for the fault detectors
// Revision: 1.0 - initial release
// ============================================================================
package fault_det_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One bit of the golden one-hot decode: output idx is high only when
  // enabled and the select value equals idx. Width independent, so any
  // N-to-2^N golden model (decoder or encoder side) can build on it.
  function automatic logic golden_decode_bit(
    input logic        en,
    input int unsigned a,
    input int unsigned idx
  );
    return en && (a == idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_gold.sv
`default_nettype none
// ============================================================================
// Module  : decoder_gold
// Brief   : Combinational golden N-to-2^N decoder with enable
// Revision: 1.0 - initial release
// ============================================================================
module decoder_gold
  import fault_det_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              en,
  input  logic [N-1:0]      a,
  output logic [(2**N)-1:0] y
);

  localparam int c_OUT_W = 2**N;

  // Each output bit is an independent compare of the select against its index
  for (genvar i = 0; i < c_OUT_W; i++) begin : g_bit
    assign y[i] = golden_decode_bit(en, 32'(a), i);
  end

endmodule
`default_nettype wire

// File: rtl/decoder_fault_detector.sv
`default_nettype none
// ============================================================================
// Module  : decoder_fault_detector
// Brief   : BIST sweep controller comparing an external N-to-2^N decoder
//           against a golden decoder over every {EN, A} combination
// Revision: 1.0 - initial release
// ============================================================================
module decoder_fault_detector
  import fault_det_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = N + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N-1:0]      tst_a,
  output logic              tst_en,
  input  logic [(2**N)-1:0] y_dut,
  output logic              busy,
  output logic              done,
  output logic              fault_detected,
  output logic [CNT_W-1:0]  fault_count,
  output logic              fail_valid,
  output logic [N:0]        first_fail_vec,
  output logic [(2**N)-1:0] first_fail_y
);

  localparam int           c_OUT_W    = 2**N;
  localparam logic [N:0]   c_LAST_VEC = '1;

  state_t             r_state;
  state_t             w_next;
  logic [N:0]         r_vec;
  logic [c_OUT_W-1:0] w_gold;
  logic               w_start_ok;
  logic               w_mismatch;
  logic               w_is_last;

  decoder_gold #(
    .N (N)
  ) u_gold (
    .en (r_vec[N]),
    .a  (r_vec[N-1:0]),
    .y  (w_gold)
  );

  // The vector register drives the DUT directly, so tst_* are registered
  assign tst_a      = r_vec[N-1:0];
  assign tst_en     = r_vec[N];
  assign busy       = (r_state == APPLY) || (r_state == CHECK);
  assign done       = (r_state == DONE);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_is_last  = (r_vec == c_LAST_VEC);
  // A CHECK is recorded even if abort arrives in the same cycle
  assign w_mismatch = (r_state == CHECK) && (y_dut != w_gold);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: abort wins over everything while busy
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next = APPLY;
      end
      APPLY: begin
        w_next = abort ? IDLE : CHECK;
      end
      CHECK: begin
        if (abort)          w_next = IDLE;
        else if (w_is_last) w_next = DONE;
        else                w_next = APPLY;
      end
      default: w_next = IDLE;
    endcase
  end

  // Vector index: reset on start, advance after each non-final CHECK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
    end else if (w_start_ok) begin
      r_vec <= '0;
    end else if ((r_state == CHECK) && !abort && !w_is_last) begin
      r_vec <= r_vec + 1'b1;
    end
  end

  // Result accumulation: sticky flag, saturating count, first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_detected <= 1'b0;
      fault_count    <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      first_fail_y   <= '0;
    end else if (w_start_ok) begin
      fault_detected <= 1'b0;
      fault_count    <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      first_fail_y   <= '0;
    end else if (w_mismatch) begin
      fault_detected <= 1'b1;
      if (fault_count != '1) begin
        fault_count <= fault_count + 1'b1;
      end
      if (!fail_valid) begin
        fail_valid     <= 1'b1;
        first_fail_vec <= r_vec;
        first_fail_y   <= y_dut;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_fault_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_decoder_fault_detector
// Brief   : Self-checking bench for decoder_fault_detector (N=2)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decoder_fault_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] sa0 = 4'd0;
  logic [3:0] sa1 = 4'd0;

  logic [1:0] tst_a;
  logic       tst_en;
  logic [3:0] y_dut;
  logic       busy, done, fault_detected, fail_valid;
  logic [3:0] fault_count;
  logic [2:0] first_fail_vec;
  logic [3:0] first_fail_y;

  // Narrow-counter instance used to exercise saturation
  logic [1:0] s_tst_a;
  logic       s_tst_en;
  logic [3:0] s_y;
  logic       s_busy, s_done, s_fault, s_valid;
  logic [1:0] s_count;
  logic [2:0] s_vec;
  logic [3:0] s_fy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_gold(input logic [2:0] v);
    logic [1:0] a;
    a = v[1:0];
    return v[2] ? (4'd1 << a) : 4'd0;
  endfunction

  // Decoder-under-test model with stuck-at faults
  always_comb y_dut = (ref_gold({tst_en, tst_a}) & ~sa0) | sa1;
  always_comb s_y   = ref_gold({s_tst_en, s_tst_a}) | 4'b0001;

  decoder_fault_detector #(.N(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tst_a(tst_a), .tst_en(tst_en), .y_dut(y_dut),
    .busy(busy), .done(done), .fault_detected(fault_detected),
    .fault_count(fault_count), .fail_valid(fail_valid),
    .first_fail_vec(first_fail_vec), .first_fail_y(first_fail_y)
  );

  decoder_fault_detector #(.N(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tst_a(s_tst_a), .tst_en(s_tst_en), .y_dut(s_y),
    .busy(s_busy), .done(s_done), .fault_detected(s_fault),
    .fault_count(s_count), .fail_valid(s_valid),
    .first_fail_vec(s_vec), .first_fail_y(s_fy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected sweep results computed directly from the fault model
  task automatic expect_results(output int cnt, output logic [2:0] fvec, output logic [3:0] fy);
    logic [3:0] y;
    cnt = 0; fvec = '0; fy = '0;
    for (int v = 0; v < 8; v++) begin
      y = (ref_gold(3'(v)) & ~sa0) | sa1;
      if (y != ref_gold(3'(v))) begin
        if (cnt == 0) begin fvec = 3'(v); fy = y; end
        cnt++;
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int restart_at);
    int edges;
    int cnt;
    logic [2:0] fvec;
    logic [3:0] fy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    check({tag, "_clr_cnt"}, fault_count, 0);
    check({tag, "_clr_valid"}, fail_valid, 0);
    check({tag, "_clr_done"}, done, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_vec0"}, {tst_en, tst_a}, 0);
    while (!done && edges < 64) begin
      start = (edges == restart_at);
      @(negedge clk);
      edges++;
      if (!done) check({tag, "_order"}, {tst_en, tst_a}, edges / 2);
    end
    start = 1'b0;
    check({tag, "_edges"}, edges, 16);
    expect_results(cnt, fvec, fy);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_last_vec"}, {tst_en, tst_a}, 7);
    check({tag, "_fault"}, fault_detected, (cnt != 0));
    check({tag, "_count"}, fault_count, (cnt > 15) ? 15 : cnt);
    check({tag, "_valid"}, fail_valid, (cnt != 0));
    check({tag, "_fvec"}, first_fail_vec, fvec);
    check({tag, "_fy"}, first_fail_y, fy);
  endtask

  initial begin
    int edges;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tst", {tst_en, tst_a}, 0);
    check("rst_count", fault_count, 0);
    check("rst_fault", fault_detected, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Fault-free sweep
    sa0 = 4'd0; sa1 = 4'd0;
    run_sweep("clean", -1);

    // y[2] stuck-at-0: only vec 6 fails
    sa0 = 4'b0100; sa1 = 4'd0;
    run_sweep("sa0_y2", -1);
    check("sa0_y2_vec6", first_fail_vec, 3'b110);
    check("sa0_y2_cnt1", fault_count, 1);

    // y[0] stuck-at-1: seven failures, first at vec 0
    sa0 = 4'd0; sa1 = 4'b0001;
    run_sweep("sa1_y0", -1);
    check("sa1_y0_cnt7", fault_count, 7);
    check("sa1_y0_fy", first_fail_y, 4'b0001);
    check("sat_count", s_count, 2'b11);
    check("sat_fault", s_fault, 1);
    check("sat_fvec", s_vec, 0);
    check("sat_fy", s_fy, 4'b0001);
    check("sat_done", s_done, 1);

    // start mid-sweep ignored, then restart from DONE
    sa0 = 4'b1000; sa1 = 4'd0;
    run_sweep("restart", 5);
    sa0 = 4'd0; sa1 = 4'b0010;
    run_sweep("from_done", -1);

    // Randomized fault masks
    for (int k = 0; k < 6; k++) begin
      sa0 = 4'($urandom);
      sa1 = 4'($urandom) & 4'($urandom);
      run_sweep("rand", -1);
    end

    // Abort on APPLY of vec 3 with y[0] stuck-at-1
    sa0 = 4'd0; sa1 = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (edges < 6) begin @(negedge clk); edges++; end
    check("abort_at_vec3", {tst_en, tst_a}, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", fault_count, 3);
    check("abort_valid", fail_valid, 1);
    check("abort_fvec", first_fail_vec, 0);
    repeat (2) @(negedge clk);
    check("abort_stay_idle", busy, 0);

    // abort in IDLE has no effect; start+abort in IDLE starts
    abort = 1'b1;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_idle_cnt", fault_count, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_wins", busy, 1);
    check("start_wins_cnt", fault_count, 0);
    // abort held: it wins while busy
    @(negedge clk);
    abort = 1'b0;
    check("abort_wins", busy, 0);
    check("abort_wins_done", done, 0);

    // Asynchronous reset mid-CHECK
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (edges < 3) begin @(negedge clk); edges++; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_tst", {tst_en, tst_a}, 0);
    check("arst_count", fault_count, 0);
    check("arst_fault", fault_detected, 0);
    check("arst_valid", fail_valid, 0);
    check("arst_fvec", first_fail_vec, 0);
    check("arst_fy", first_fail_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_tst", {tst_en, tst_a}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
